lvds_echo_onchip_mem_arbiter: RTL
=================================

// Module: lvds_echo_onchip_mem_arbiter
// PURPOSE
//  Two-requester Avalon-MM arbiter in front of the 8192x32 single-port on-chip RAM (1-cycle sync read).
//  m0 = LVDS echo RX/TX datapath, m1 = Nios/control master. One command reaches the RAM per clk.
//  Returns read data with readdatavalid to the issuing master only; waitrequest throttles the loser.
// PARAMETERS
//  ADDR_W         13  word address width (8192 words)
//  DATA_W         32  data width; byteenable width = DATA_W/8
//  READ_LATENCY    1  clk cycles from command accept to valid mem_readdata (1..4)
//  FIXED_PRIORITY  0  0 = round-robin; 1 = m0 always wins on conflict
// PORTS
//  clk               in   1        system clock
//  reset_n           in   1        asynchronous reset, active low
//  mN_address        in   ADDR_W   word address, N = 0,1
//  mN_read           in   1        read request
//  mN_write          in   1        write request
//  mN_byteenable     in   DATA_W/8 byte lanes for write
//  mN_writedata      in   DATA_W   write data
//  mN_waitrequest    out  1        1 = command not accepted this cycle; master holds it
//  mN_readdata       out  DATA_W   read data, qualified by mN_readdatavalid
//  mN_readdatavalid  out  1        one pulse per accepted read of master N
//  mem_address       out  ADDR_W   to RAM address
//  mem_byteenable    out  DATA_W/8 to RAM byteenable
//  mem_chipselect    out  1        to RAM chipselect
//  mem_write         out  1        to RAM write
//  mem_writedata     out  DATA_W   to RAM writedata
//  mem_readdata      in   DATA_W   from RAM readdata
// BEHAVIOUR
//  - reqN = mN_read | mN_write. Grant combinational from reqN and registered pointer rr_last.
//  - Round-robin: one requester -> it wins; both -> master != rr_last wins. rr_last <= winner on every grant.
//    No grant -> rr_last holds. FIXED_PRIORITY=1: m0 wins every conflict; rr_last unused.
//  - mN_waitrequest = ~grantN (high when idle or losing). Accept = reqN & grantN; 0 wait-states when uncontended.
//  - mem_chipselect = any grant; mem_address/byteenable/writedata/write mux from winner.
//    With no grant: mem_write = 0, other mem_* outputs hold m0 values (don't care).
//  - Read and write both high on one master = write only; no readdatavalid generated.
//  - Read return: READ_LATENCY-deep shift register of {valid, id}; entry = {accepted read, winner}.
//    At the tail: m<id>_readdatavalid = 1, both mN_readdata = mem_readdata (unqualified for other id).
//  - Back-to-back reads are fully pipelined; return order = accept order. Throughput 1 command/clk.
//  - Write accept and read return to the other master in the same cycle are legal; they are independent.
//  - reset_n low (async): rr_last <= m1 (so m0 wins first conflict), pipeline cleared;
//    while low: grants forced 0, mN_waitrequest = 1, mN_readdatavalid = 0,
//    mem_chipselect = 0, mem_write = 0.
//  - Reset mid-read: in-flight reads dropped; no readdatavalid after reset release for them.
//  - Requests held across reset are re-arbitrated on the first clk after release.
// TESTING
//  1 m0 write addr 0x0010 data 0xDEADBEEF be 0xF, m1 idle -> m0_waitrequest=0 same cycle; mem_write=1 one clk.
//    Then m0 read 0x0010 -> m0_readdatavalid 1 clk later with 0xDEADBEEF; m1_readdatavalid stays 0.
//  2 m0 and m1 read continuously (0x100.., 0x200..) for 8 clks -> grants alternate m0,m1,...
//    starting m0 after reset; each master gets 4 reads; valids return in the same order.
//  3 FIXED_PRIORITY=1, both request for 5 clks -> m0 granted all 5; m1_waitrequest=1 throughout;
//    m1 accepted the clk m0 drops its request.
//  4 m1 write be=4'b0011 data 0x12345678 to 0x1FFF (top word), after init 0xFFFFFFFF -> readback 0xFFFF5678.
//  5 m0 read accepted; reset_n pulsed low before the return clk -> no m0_readdatavalid;
//    all outputs at reset values during reset; normal operation on first clk after release.
//  6 m0 asserts read+write together at 0x0040 -> write performed; mem_write=1; no readdatavalid.
//    READ_LATENCY=3 run of scenario 2 -> every valid arrives exactly 3 clks after its accept.

Source files
------------

// File: rtl/lvds_echo_onchip_mem_arbiter.sv
// lvds_echo_onchip_mem_arbiter: two-master Avalon-MM arbiter in front of a single-port sync-read RAM
//   clk, reset_n : system clock, asynchronous active-low reset
//   m0_*         : LVDS echo datapath master (address/read/write/byteenable/writedata in,
//                  waitrequest/readdata/readdatavalid out)
//   m1_*         : Nios/control master, same signal set as m0
//   mem_*        : RAM command outputs; mem_readdata valid READ_LATENCY clks after accept
module lvds_echo_onchip_mem_arbiter #(
   parameter int ADDR_W         = 13,
   parameter int DATA_W         = 32,
   parameter int READ_LATENCY   = 1,
   parameter int FIXED_PRIORITY = 0
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [ADDR_W-1:0]   m0_address,
   input  logic                m0_read,
   input  logic                m0_write,
   input  logic [DATA_W/8-1:0] m0_byteenable,
   input  logic [DATA_W-1:0]   m0_writedata,
   output logic                m0_waitrequest,
   output logic [DATA_W-1:0]   m0_readdata,
   output logic                m0_readdatavalid,
   input  logic [ADDR_W-1:0]   m1_address,
   input  logic                m1_read,
   input  logic                m1_write,
   input  logic [DATA_W/8-1:0] m1_byteenable,
   input  logic [DATA_W-1:0]   m1_writedata,
   output logic                m1_waitrequest,
   output logic [DATA_W-1:0]   m1_readdata,
   output logic                m1_readdatavalid,
   output logic [ADDR_W-1:0]   mem_address,
   output logic [DATA_W/8-1:0] mem_byteenable,
   output logic                mem_chipselect,
   output logic                mem_write,
   output logic [DATA_W-1:0]   mem_writedata,
   input  logic [DATA_W-1:0]   mem_readdata
);
   logic req0, req1, gnt0, gnt1, rd_acc, rr_last_q, rr_last_d;
   logic [READ_LATENCY-1:0] vld_q, vld_d, id_q, id_d;
   assign req0 = m0_read | m0_write;
   assign req1 = m1_read | m1_write;
   // m0 takes a conflict under fixed priority or when m1 held the last grant
   assign gnt0 = reset_n & req0 & (~req1 | rr_last_q | (FIXED_PRIORITY != 0));
   assign gnt1 = reset_n & req1 & ~gnt0;
   // read+write together is treated as a write, so it never enters the return pipe
   assign rd_acc    = gnt0 ? m0_read & ~m0_write : gnt1 & m1_read & ~m1_write;
   assign rr_last_d = (gnt0 | gnt1) ? gnt1 : rr_last_q;
   // return pipe: bit 0 enters this cycle, bit READ_LATENCY-1 lines up with mem_readdata
   assign vld_d = (vld_q << 1) | READ_LATENCY'(rd_acc);
   assign id_d  = (id_q << 1) | READ_LATENCY'(gnt1);
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         rr_last_q <= 1'b1;
         vld_q     <= '0;
         id_q      <= '0;
      end else begin
         rr_last_q <= rr_last_d;
         vld_q     <= vld_d;
         id_q      <= id_d;
      end
   assign m0_waitrequest   = ~gnt0;
   assign m1_waitrequest   = ~gnt1;
   assign m0_readdatavalid = vld_q[READ_LATENCY-1] & ~id_q[READ_LATENCY-1];
   assign m1_readdatavalid = vld_q[READ_LATENCY-1] & id_q[READ_LATENCY-1];
   assign m0_readdata      = mem_readdata;
   assign m1_readdata      = mem_readdata;
   assign mem_chipselect   = gnt0 | gnt1;
   assign mem_write        = gnt1 ? m1_write : gnt0 & m0_write;
   assign mem_address      = gnt1 ? m1_address : m0_address;
   assign mem_byteenable   = gnt1 ? m1_byteenable : m0_byteenable;
   assign mem_writedata    = gnt1 ? m1_writedata : m0_writedata;
endmodule
